// File: rtl/alu_op_sequencer.sv
// ---------------------------------------------------------------------------
// alu_op_sequencer
//
// Buffers ALU operation requests in a small circular queue and feeds them,
// one at a time, to an external combinational ALU.
//
// Each operation takes one cycle in EXEC while the external ALU settles.
// The result is then captured and presented downstream with a valid/ready
// handshake. While a result waits for acceptance, new requests can still
// enter the queue.
//
// Ports
//   clk, rst_n           : clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready  : upstream request handshake
//   in_a, in_b, in_sel   : request operands and ALU select code
//   alu_a, alu_b, alu_sel: registered operands/select driven to the ALU
//   alu_out, alu_co      : ALU result and carry-out coming back
//   res_valid / res_ready: downstream result handshake
//   res_data, res_co     : captured ALU result and carry
//   res_sel              : select code that produced res_data
//   count                : current queue occupancy
//   done_cnt             : completed results, wraps 255 -> 0
// ---------------------------------------------------------------------------
module alu_op_sequencer #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [W-1:0]           in_a,
  input  logic [W-1:0]           in_b,
  input  logic [1:0]             in_sel,
  output logic [W-1:0]           alu_a,
  output logic [W-1:0]           alu_b,
  output logic [1:0]             alu_sel,
  input  logic [W-1:0]           alu_out,
  input  logic                   alu_co,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [W-1:0]           res_data,
  output logic                   res_co,
  output logic [1:0]             res_sel,
  output logic [$clog2(DEPTH):0] count,
  output logic [7:0]             done_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = 2 * W + 2;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [EW-1:0]   mem_q [DEPTH];
  logic [EW-1:0]   mem_d [DEPTH];
  logic [W-1:0]    alu_a_q, alu_a_d;
  logic [W-1:0]    alu_b_q, alu_b_d;
  logic [1:0]      alu_sel_q, alu_sel_d;
  logic            res_valid_q, res_valid_d;
  logic [W-1:0]    res_data_q, res_data_d;
  logic            res_co_q, res_co_d;
  logic [1:0]      res_sel_q, res_sel_d;
  logic [7:0]      done_cnt_q, done_cnt_d;

  logic            in_ready_int;
  logic            push;
  logic            pop;

  // Readiness comes from the registered occupancy only, so a full queue
  // refuses a request even if an entry is popped in the same cycle.
  assign in_ready_int = (count_q < DEPTH_C);

  // Next-state logic: FSM sequencing, result capture, queue push/pop.
  // A pop reads the head as it stood before this edge, so an entry being
  // pushed in the same cycle is never popped before it is stored.
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    mem_d       = mem_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_sel_d   = alu_sel_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_co_d    = res_co_q;
    res_sel_d   = res_sel_q;
    done_cnt_d  = done_cnt_q;
    push        = in_valid && in_ready_int;
    pop         = 1'b0;

    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        // The ALU has had a full cycle on the registered operands.
        res_valid_d = 1'b1;
        res_data_d  = alu_out;
        res_co_d    = alu_co;
        res_sel_d   = alu_sel_q;
        state_d     = DONE;
      end
      DONE: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          done_cnt_d  = done_cnt_q + 8'd1;
          if (count_q != '0) begin
            pop     = 1'b1;
            state_d = EXEC;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (pop) begin
      {alu_sel_d, alu_b_d, alu_a_d} = mem_q[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + PW'(1);
    end

    if (push) begin
      mem_d[wr_ptr_q] = {in_sel, in_b, in_a};
      wr_ptr_d = wr_ptr_q + PW'(1);
    end

    count_d = count_q + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};
  end

  // State registers; reset discards queued entries and any pending result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_sel_q   <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_co_q    <= 1'b0;
      res_sel_q   <= '0;
      done_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      mem_q       <= mem_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_sel_q   <= alu_sel_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_co_q    <= res_co_d;
      res_sel_q   <= res_sel_d;
      done_cnt_q  <= done_cnt_d;
    end
  end

  assign in_ready  = in_ready_int;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_sel   = alu_sel_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_co    = res_co_q;
  assign res_sel   = res_sel_q;
  assign count     = count_q;
  assign done_cnt  = done_cnt_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_op_sequencer
//
// Drives alu_op_sequencer together with a behavioural ALU. The ALU performs
// A+B, A-B, A&B or A^B for select codes 0 to 3. Its carry output is bit W of
// the widened result.
//
// A queue-based reference model predicts every output on every cycle.
// Directed scenarios pin specific values:
//   - single-op latency
//   - filling the queue and stalling the result
//   - a long randomized stream
//   - reset in the middle of an operation
// ---------------------------------------------------------------------------
module tb_alu_op_sequencer;

  localparam int DEPTH = 4;
  localparam int W     = 8;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [1:0]   sel;
  } op_t;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic [1:0]   in_sel;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic [1:0]   alu_sel;
  logic [W-1:0] alu_out;
  logic         alu_co;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] res_data;
  logic         res_co;
  logic [1:0]   res_sel;
  logic [2:0]   count;
  logic [7:0]   done_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model state
  op_t          m_q[$];
  op_t          m_alu = '0;
  op_t          m_new;
  int           m_stage = 0;
  logic [W:0]   m_res = '0;
  logic [1:0]   m_res_sel = '0;
  logic         m_res_valid = 1'b0;
  logic [7:0]   m_done = '0;
  int           m_total = 0;
  int           m_sz;
  logic         m_push;
  logic         m_pop;

  // Results seen leaving the DUT, as {sel, co, data}
  logic [10:0]  got_q[$];

  alu_op_sequencer #(.DEPTH(DEPTH), .W(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_sel   (in_sel),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_sel  (alu_sel),
    .alu_out  (alu_out),
    .alu_co   (alu_co),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_data (res_data),
    .res_co   (res_co),
    .res_sel  (res_sel),
    .count    (count),
    .done_cnt (done_cnt)
  );

  function automatic logic [W:0] alu_fn(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic [1:0] s);
    case (s)
      2'd0:    return {1'b0, a} + {1'b0, b};
      2'd1:    return {1'b0, a} - {1'b0, b};
      2'd2:    return {1'b0, a & b};
      default: return {1'b0, a ^ b};
    endcase
  endfunction

  // Behavioural combinational ALU sitting outside the DUT
  always_comb begin
    {alu_co, alu_out} = alu_fn(alu_a, alu_b, alu_sel);
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one request and hold it until the DUT takes it
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] s);
    int   waited;
    logic accepted;
    waited   = 0;
    accepted = 1'b0;
    in_a     = a;
    in_b     = b;
    in_sel   = s;
    in_valid = 1'b1;
    while (!accepted && waited < 64) begin
      accepted = in_ready;
      tick();
      waited++;
    end
    in_valid = 1'b0;
    checkOutput("push_accept", 32'(accepted), 32'd1);
  endtask

  task automatic resetDut();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    res_ready = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  task automatic waitTotal(input int target, input int budget);
    int n;
    n = 0;
    while (m_total < target && n < budget) begin
      tick();
      n++;
    end
    checkOutput("drain_in_time", 32'(m_total >= target), 32'd1);
  endtask

  // Reference model: advances on every rising edge from the sampled inputs
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_q.delete();
      m_alu       = '0;
      m_stage     = 0;
      m_res       = '0;
      m_res_sel   = '0;
      m_res_valid = 1'b0;
      m_done      = '0;
    end else begin
      m_sz   = m_q.size();
      m_push = in_valid && (m_sz < DEPTH);
      m_pop  = 1'b0;
      if (m_stage == 0) begin
        m_pop = (m_sz > 0);
      end else if (m_stage == 1) begin
        m_res       = alu_fn(m_alu.a, m_alu.b, m_alu.sel);
        m_res_sel   = m_alu.sel;
        m_res_valid = 1'b1;
        m_stage     = 2;
      end else if (res_ready) begin
        m_done++;
        m_total++;
        m_res_valid = 1'b0;
        m_stage     = 0;
        m_pop       = (m_sz > 0);
      end
      if (m_pop) begin
        m_alu   = m_q.pop_front();
        m_stage = 1;
      end
      if (m_push) begin
        m_new.a   = in_a;
        m_new.b   = in_b;
        m_new.sel = in_sel;
        m_q.push_back(m_new);
      end
    end
  end

  // Compare process: every output against the model on each falling edge
  initial forever begin
    @(negedge clk);
    checkOutput("in_ready",  32'(in_ready),  32'(m_q.size() < DEPTH));
    checkOutput("count",     32'(count),     32'(m_q.size()));
    checkOutput("res_valid", 32'(res_valid), 32'(m_res_valid));
    checkOutput("res_data",  32'(res_data),  32'(m_res[W-1:0]));
    checkOutput("res_co",    32'(res_co),    32'(m_res[W]));
    checkOutput("res_sel",   32'(res_sel),   32'(m_res_sel));
    checkOutput("alu_a",     32'(alu_a),     32'(m_alu.a));
    checkOutput("alu_b",     32'(alu_b),     32'(m_alu.b));
    checkOutput("alu_sel",   32'(alu_sel),   32'(m_alu.sel));
    checkOutput("done_cnt",  32'(done_cnt),  32'(m_done));
    if (rst_n && res_valid && res_ready) begin
      got_q.push_back({res_sel, res_co, res_data});
    end
  end

  initial begin
    logic [10:0] fill_exp [5];
    int          base;
    int          target;
    bit          pushing_done;

    fill_exp[0] = {2'd0, 1'b0, 8'h30};
    fill_exp[1] = {2'd0, 1'b1, 8'h10};
    fill_exp[2] = {2'd2, 1'b0, 8'h05};
    fill_exp[3] = {2'd3, 1'b0, 8'h3C};
    fill_exp[4] = {2'd1, 1'b1, 8'hFE};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_sel    = '0;
    res_ready = 1'b0;
    #2;
    checkOutput("rst_in_ready",  32'(in_ready),  32'd1);
    checkOutput("rst_count",     32'(count),     32'd0);
    checkOutput("rst_res_valid", 32'(res_valid), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;

    // Single operation: latency and literal result
    $display("[TB] single operation");
    applyStimulus(8'h6A, 8'h26, 2'd0);
    checkOutput("single_k_count", 32'(count), 32'd1);
    tick();
    checkOutput("single_k1_alu_a",     32'(alu_a),     32'h6A);
    checkOutput("single_k1_res_valid", 32'(res_valid), 32'd0);
    tick();
    checkOutput("single_k2_res_valid", 32'(res_valid), 32'd1);
    checkOutput("single_k2_res_data",  32'(res_data),  32'h90);
    checkOutput("single_k2_res_co",    32'(res_co),    32'd0);
    checkOutput("single_k2_res_sel",   32'(res_sel),   32'd0);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    checkOutput("single_done_cnt",  32'(done_cnt),  32'd1);
    checkOutput("single_res_clear", 32'(res_valid), 32'd0);

    // Fill the queue behind a stalled result, then drain in order
    $display("[TB] fill and stall");
    resetDut();
    applyStimulus(8'h10, 8'h20, 2'd0);
    applyStimulus(8'hF0, 8'h20, 2'd0);
    applyStimulus(8'h55, 8'h0F, 2'd2);
    applyStimulus(8'h33, 8'h0F, 2'd3);
    applyStimulus(8'h05, 8'h07, 2'd1);
    checkOutput("fill_count",    32'(count),    32'd4);
    checkOutput("fill_in_ready", 32'(in_ready), 32'd0);
    in_a     = 8'hEE;
    in_b     = 8'hEE;
    in_sel   = 2'd0;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checkOutput("stall_res_valid", 32'(res_valid), 32'd1);
      checkOutput("stall_res_data",  32'(res_data),  32'h30);
      checkOutput("stall_res_co",    32'(res_co),    32'd0);
      checkOutput("stall_res_sel",   32'(res_sel),   32'd0);
      checkOutput("stall_done_cnt",  32'(done_cnt),  32'd0);
      checkOutput("stall_count",     32'(count),     32'd4);
    end
    in_valid  = 1'b0;
    base      = got_q.size();
    res_ready = 1'b1;
    waitTotal(m_total + 5, 100);
    res_ready = 1'b0;
    tick();
    checkOutput("fill_result_count", 32'(got_q.size() - base), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (base + i < got_q.size()) begin
        checkOutput("fill_result", 32'(got_q[base + i]), 32'(fill_exp[i]));
      end
    end

    // Long randomized stream with random back-pressure
    $display("[TB] randomized stream");
    resetDut();
    base         = got_q.size();
    target       = m_total + 300;
    pushing_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          if ($urandom_range(0, 3) == 0) tick();
          applyStimulus(W'($urandom), W'($urandom), 2'($urandom_range(0, 3)));
        end
        pushing_done = 1'b1;
      end
      begin
        int guard;
        guard = 0;
        while (m_total < target && guard < 20000) begin
          res_ready = ($urandom_range(0, 3) != 0);
          tick();
          guard++;
        end
        res_ready = 1'b0;
      end
    join
    checkOutput("wrap_pushes_done", 32'(pushing_done), 32'd1);
    checkOutput("wrap_drained",     32'(m_total >= target), 32'd1);
    tick();
    checkOutput("wrap_result_count", 32'(got_q.size() - base), 32'd300);
    checkOutput("wrap_done_cnt",     32'(done_cnt), 32'd44);

    // Reset while an operation is executing with three entries queued
    $display("[TB] reset mid-operation");
    res_ready = 1'b0;
    applyStimulus(8'h01, 8'h02, 2'd0);
    applyStimulus(8'h03, 8'h04, 2'd1);
    applyStimulus(8'h05, 8'h06, 2'd2);
    applyStimulus(8'h07, 8'h08, 2'd3);
    res_ready = 1'b1;
    applyStimulus(8'h09, 8'h0A, 2'd0);
    res_ready = 1'b0;
    checkOutput("pre_rst_count",     32'(count),     32'd3);
    checkOutput("pre_rst_res_valid", 32'(res_valid), 32'd0);
    checkOutput("pre_rst_alu_a",     32'(alu_a),     32'h03);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_in_ready",  32'(in_ready),  32'd1);
    checkOutput("async_count",     32'(count),     32'd0);
    checkOutput("async_res_valid", 32'(res_valid), 32'd0);
    checkOutput("async_res_data",  32'(res_data),  32'd0);
    checkOutput("async_res_co",    32'(res_co),    32'd0);
    checkOutput("async_res_sel",   32'(res_sel),   32'd0);
    checkOutput("async_alu_a",     32'(alu_a),     32'd0);
    checkOutput("async_alu_b",     32'(alu_b),     32'd0);
    checkOutput("async_alu_sel",   32'(alu_sel),   32'd0);
    checkOutput("async_done_cnt",  32'(done_cnt),  32'd0);
    tick();
    tick();
    rst_n     = 1'b1;
    res_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checkOutput("post_rst_res_valid", 32'(res_valid), 32'd0);
      checkOutput("post_rst_count",     32'(count),     32'd0);
      checkOutput("post_rst_done_cnt",  32'(done_cnt),  32'd0);
    end
    res_ready = 1'b0;

    // First request after release goes straight through
    applyStimulus(8'hFF, 8'h01, 2'd0);
    checkOutput("post_rst_push_count", 32'(count), 32'd1);
    tick();
    tick();
    checkOutput("post_rst_res_data", 32'(res_data), 32'h00);
    checkOutput("post_rst_res_co",   32'(res_co),   32'd1);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning number of operation-queue entries (power of two, at least 2).
REQ-002 The block SHALL have parameter W, default 8, meaning the operand and result width.
REQ-003 The block SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, meaning an asynchronous, active-low reset.
REQ-005 The block SHALL have port in_valid, input, 1, meaning the upstream operation request is valid.
REQ-006 The block SHALL have port in_ready, output, 1, meaning the queue can accept a request.
REQ-007 The block SHALL have port in_a, input, W, meaning signed operand A.
REQ-008 The block SHALL have port in_b, input, W, meaning signed operand B.
REQ-009 The block SHALL have port in_sel, input, 2, meaning the ALU select code.
REQ-010 The block SHALL have ports alu_a (output, W), alu_b (output, W) and alu_sel (output, 2), meaning registered operands and select driven to the combinational ALU.
REQ-011 The block SHALL have ports alu_out (input, W) and alu_co (input, 1), meaning the ALU result and carry-out.
REQ-012 The block SHALL have port res_valid, output, 1, meaning a captured result is presented.
REQ-013 The block SHALL have port res_ready, input, 1, meaning the downstream consumer accepts the result.
REQ-014 The block SHALL have ports res_data (output, W) and res_co (output, 1), meaning the captured ALU result and carry.
REQ-015 The block SHALL have port res_sel, output, 2, meaning the select code that produced res_data.
REQ-016 The block SHALL have port count, output, log2(DEPTH)+1, meaning current queue occupancy.
REQ-017 The block SHALL have port done_cnt, output, 8, meaning completed results, wrapping 255->0.

Function
REQ-018 Queue: circular FIFO of DEPTH entries {in_a, in_b, in_sel}; push when in_valid && in_ready; wr/rd pointers wrap DEPTH-1 -> 0.
REQ-019 in_ready SHALL equal (count < DEPTH), derived from registered state only; no push-through bypass when full, even if a pop occurs in the same cycle.
REQ-020 Simultaneous push and pop SHALL leave count unchanged and store the pushed entry correctly; in_valid while full SHALL be ignored with no state change.
REQ-021 FSM states SHALL be IDLE, EXEC and DONE.
REQ-022 IDLE: if count > 0, pop the head into alu_a/alu_b/alu_sel and go to EXEC; otherwise remain in IDLE.
REQ-023 EXEC (exactly one cycle): at the ending edge, capture alu_out->res_data, alu_co->res_co and alu_sel->res_sel, set res_valid=1, and go to DONE.
REQ-024 DONE: res_valid=1 and res_data/res_co/res_sel are held stable until the handshake.
REQ-025 DONE with res_ready=1 and count > 0 SHALL clear res_valid and increment done_cnt, then pop the head into the alu_* registers and go to EXEC.
REQ-026 DONE with res_ready=1 and count == 0 SHALL clear res_valid and increment done_cnt, then go to IDLE.
REQ-027 DONE with res_ready=0 SHALL be a stall: hold all outputs; pushes continue while the queue has room.
REQ-028 Latency: a request pushed at edge k into an empty queue in IDLE SHALL be popped at edge k+1, with res_valid=1 after edge k+2.
REQ-029 Back-to-back throughput with res_ready held at 1 SHALL be one result per 2 cycles.
REQ-030 Operands and results SHALL pass bit-exact with no sign extension, truncation or modification; carry comes only from alu_co.
REQ-031 alu_a/alu_b/alu_sel SHALL change only on a pop and hold their value otherwise.

Reset
REQ-032 When rst_n=0, asynchronously: pointers=0, count=0, state=IDLE, res_valid=0, res_data=0, res_co=0, res_sel=0, alu_a=0, alu_b=0, alu_sel=0, done_cnt=0.
REQ-033 Reset mid-operation SHALL discard queued entries and any in-flight or presented result; in_ready=1 during and after reset.
REQ-034 The first push is accepted on the first rising edge with rst_n=1.

Verification
REQ-035 The bench SHALL use a behavioural ALU model with sel0 = A+B, carry = bit W.
REQ-036 Single op: push A=0x6A, B=0x26, sel=0 at edge k -> res_valid after k+2, res_data=0x90, res_co=0, res_sel=0, done_cnt=1.
REQ-037 Fill: 5 pushes with res_ready=0 -> first popped, next 4 queued, count=4, in_ready=0, 5th not lost; release res_ready -> 5 results in push order.
REQ-038 Stall: res_ready=0 for 10 cycles in DONE -> res_data/res_co/res_sel stable throughout, done_cnt unchanged.
REQ-039 Wrap: 300 ops streamed with random res_ready -> all results match the model in order; pointers wrap; done_cnt=44.
REQ-040 Reset: assert rst_n=0 in EXEC with count=3 -> all outputs at reset values immediately, and no stale result appears after release.
